// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - song ROM note sequencer driving a duration timer and tone generator
module note_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              play,
    input  logic              loop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [7:0]        dur,
    output logic              dur_start,
    input  logic              dur_done,
    output logic [7:0]        pitch,
    output logic              busy,
    output logic              song_end
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_END
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    // Last value of the gap counter before moving on; unused when the gap is skipped.
    localparam logic [7:0] GAP_LAST = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] rom_addr_nx;
    logic [7:0]        dur_nx;
    logic              dur_start_nx;
    logic [7:0]        pitch_nx;
    logic              busy_nx;
    logic              song_end_nx;
    logic [7:0]        gap_cnt;
    logic [7:0]        gap_cnt_nx;

    // Next-state and next-output logic; every output is computed here and registered below.
    always_comb begin
        state_nx     = state;
        rom_addr_nx  = rom_addr;
        dur_nx       = dur;
        dur_start_nx = 1'b0;
        pitch_nx     = pitch;
        song_end_nx  = 1'b0;
        gap_cnt_nx   = gap_cnt;

        if (state != S_IDLE && !play) begin
            // Pause: drop to IDLE immediately, silence the tone and keep the address so
            // the current note replays from its start on resume.
            state_nx   = S_IDLE;
            pitch_nx   = 8'd0;
            gap_cnt_nx = 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    pitch_nx = 8'd0;
                    if (play) begin
                        state_nx = S_FETCH;
                    end
                end
                S_FETCH: begin
                    // rom_addr is held this cycle so the ROM word is valid in LOAD.
                    state_nx = S_LOAD;
                end
                S_LOAD: begin
                    if (rom_data[7:0] == 8'd0) begin
                        state_nx    = S_END;
                        song_end_nx = 1'b1;
                        rom_addr_nx = '0;
                    end else begin
                        pitch_nx     = rom_data[15:8];
                        dur_nx       = rom_data[7:0];
                        dur_start_nx = 1'b1;
                        state_nx     = S_PLAY;
                    end
                end
                S_PLAY: begin
                    // A done pulse alongside our own start pulse belongs to an older note.
                    if (dur_done && !dur_start) begin
                        pitch_nx = 8'd0;
                        if (GAP_CYCLES == 0) begin
                            rom_addr_nx = rom_addr + ADDR_ONE;
                            state_nx    = S_FETCH;
                        end else begin
                            gap_cnt_nx = 8'd0;
                            state_nx   = S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt_nx  = 8'd0;
                        rom_addr_nx = rom_addr + ADDR_ONE;
                        state_nx    = S_FETCH;
                    end else begin
                        gap_cnt_nx = gap_cnt + 8'd1;
                    end
                end
                S_END: begin
                    // play is known to be 1 here; the pause branch handles play=0.
                    if (loop) begin
                        state_nx = S_FETCH;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                    pitch_nx = 8'd0;
                end
            endcase
        end

        busy_nx = (state_nx != S_IDLE);
    end

    // State and registered outputs, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            rom_addr  <= '0;
            dur       <= 8'd0;
            dur_start <= 1'b0;
            pitch     <= 8'd0;
            busy      <= 1'b0;
            song_end  <= 1'b0;
            gap_cnt   <= 8'd0;
        end else begin
            state     <= state_nx;
            rom_addr  <= rom_addr_nx;
            dur       <= dur_nx;
            dur_start <= dur_start_nx;
            pitch     <= pitch_nx;
            busy      <= busy_nx;
            song_end  <= song_end_nx;
            gap_cnt   <= gap_cnt_nx;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - directed self-checking bench for note_sequencer
module tb_note_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        play_a, loop_a, inj_a;
    logic        play_b, loop_b;

    logic [7:0]  addr_a;
    logic [15:0] rdata_a;
    logic [7:0]  dur_a, pitch_a;
    logic        ds_a, done_a, busy_a, se_a;
    logic [7:0]  tcnt_a = 8'd0;
    logic [15:0] mem_a [256];

    logic [1:0]  addr_b;
    logic [15:0] rdata_b;
    logic [7:0]  dur_b, pitch_b;
    logic        ds_b, done_b, busy_b, se_b;
    logic [7:0]  tcnt_b = 8'd0;
    logic [15:0] mem_b [4];

    int n_vec = 0;
    int n_err = 0;

    note_sequencer #(.ADDR_W(8), .GAP_CYCLES(2)) u_a (
        .clk(clk), .reset_n(reset_n), .play(play_a), .loop(loop_a),
        .rom_addr(addr_a), .rom_data(rdata_a), .dur(dur_a), .dur_start(ds_a),
        .dur_done(done_a), .pitch(pitch_a), .busy(busy_a), .song_end(se_a)
    );

    note_sequencer #(.ADDR_W(2), .GAP_CYCLES(0)) u_b (
        .clk(clk), .reset_n(reset_n), .play(play_b), .loop(loop_b),
        .rom_addr(addr_b), .rom_data(rdata_b), .dur(dur_b), .dur_start(ds_b),
        .dur_done(done_b), .pitch(pitch_b), .busy(busy_b), .song_end(se_b)
    );

    // Synchronous ROMs: data valid the cycle after the address.
    always @(posedge clk) rdata_a <= mem_a[addr_a];
    always @(posedge clk) rdata_b <= mem_b[addr_b];

    // Duration timers: done pulses dur cycles after the dur_start cycle.
    always @(posedge clk) begin
        if (ds_a) tcnt_a <= dur_a;
        else if (tcnt_a != 8'd0) tcnt_a <= tcnt_a - 8'd1;
    end
    always @(posedge clk) begin
        if (ds_b) tcnt_b <= dur_b;
        else if (tcnt_b != 8'd0) tcnt_b <= tcnt_b - 8'd1;
    end
    assign done_a = (tcnt_a == 8'd1) | inj_a;
    assign done_b = (tcnt_b == 8'd1);

    function automatic logic [31:0] pk(input logic [7:0] a, input logic [7:0] p, input logic [7:0] d,
                                       input logic s, input logic e, input logic b);
        return {5'b0, a, p, d, s, e, b};
    endfunction

    function automatic logic [31:0] obs_a();
        return pk(addr_a, pitch_a, dur_a, ds_a, se_a, busy_a);
    endfunction

    function automatic logic [31:0] obs_b();
        return pk({6'b0, addr_b}, pitch_b, dur_b, ds_b, se_b, busy_b);
    endfunction

    function automatic logic [31:0] exp_p1(input int c);
        case (c)
            0, 1:    return pk(8'd0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b1);
            2:       return pk(8'd0, 8'h40, 8'd3, 1'b1, 1'b0, 1'b1);
            3, 4, 5: return pk(8'd0, 8'h40, 8'd3, 1'b0, 1'b0, 1'b1);
            6, 7:    return pk(8'd0, 8'h00, 8'd3, 1'b0, 1'b0, 1'b1);
            8, 9:    return pk(8'd1, 8'h00, 8'd3, 1'b0, 1'b0, 1'b1);
            10:      return pk(8'd0, 8'h00, 8'd3, 1'b0, 1'b1, 1'b1);
            default: return pk(8'd0, 8'h00, 8'd3, 1'b0, 1'b0, 1'b0);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int se_cnt;
        int ds_cnt;
        int found;

        reset_n = 1'b0;
        play_a = 1'b0; loop_a = 1'b0; inj_a = 1'b0;
        play_b = 1'b0; loop_b = 1'b0;
        for (int i = 0; i < 256; i++) mem_a[i] = 16'h0000;
        mem_a[0] = 16'h4003;
        mem_a[1] = 16'h0000;
        mem_b[0] = 16'h1001;
        mem_b[1] = 16'h0001;
        mem_b[2] = 16'h2001;
        mem_b[3] = 16'h3001;

        repeat (3) @(negedge clk);
        chk("reset_a", obs_a(), 32'd0);
        chk("reset_b", obs_b(), 32'd0);

        // Small-address song without end marker, no gap: wraps and never ends.
        play_b = 1'b1;
        reset_n = 1'b1;
        se_cnt = 0;
        for (int c = 0; c <= 16; c++) begin
            @(negedge clk);
            se_cnt += int'(se_b);
            if (c % 4 == 0) chk($sformatf("b_addr_c%0d", c), {30'd0, addr_b}, (c / 4) % 4);
            case (c)
                2:  chk("b_note0", obs_b(), pk(8'd0, 8'h10, 8'd1, 1'b1, 1'b0, 1'b1));
                3:  chk("b_note0_end", obs_b(), pk(8'd0, 8'h10, 8'd1, 1'b0, 1'b0, 1'b1));
                6:  chk("b_rest", obs_b(), pk(8'd1, 8'h00, 8'd1, 1'b1, 1'b0, 1'b1));
                7:  chk("b_rest_end", obs_b(), pk(8'd1, 8'h00, 8'd1, 1'b0, 1'b0, 1'b1));
                10: chk("b_note2", obs_b(), pk(8'd2, 8'h20, 8'd1, 1'b1, 1'b0, 1'b1));
                14: chk("b_note3", obs_b(), pk(8'd3, 8'h30, 8'd1, 1'b1, 1'b0, 1'b1));
                default: ;
            endcase
        end
        chk("b_no_song_end", se_cnt, 0);
        play_b = 1'b0;

        // Single note then end marker, no loop.
        play_a = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            chk($sformatf("a_pass1_c%0d", c), obs_a(), exp_p1(c));
        end

        // Same song looping: one song_end per pass, back-to-back restart.
        loop_a = 1'b1;
        se_cnt = 0;
        ds_cnt = 0;
        for (int r = 0; r <= 21; r++) begin
            @(negedge clk);
            se_cnt += int'(se_a);
            ds_cnt += int'(ds_a);
            case (r)
                10: chk("a_loop_end", obs_a(), pk(8'd0, 8'h00, 8'd3, 1'b0, 1'b1, 1'b1));
                11: chk("a_loop_fetch", obs_a(), pk(8'd0, 8'h00, 8'd3, 1'b0, 1'b0, 1'b1));
                12: chk("a_loop_load", obs_a(), pk(8'd0, 8'h00, 8'd3, 1'b0, 1'b0, 1'b1));
                13: chk("a_loop_restart", obs_a(), pk(8'd0, 8'h40, 8'd3, 1'b1, 1'b0, 1'b1));
                default: ;
            endcase
        end
        chk("a_loop_song_ends", se_cnt, 2);
        chk("a_loop_dur_starts", ds_cnt, 2);
        play_a = 1'b0;
        loop_a = 1'b0;
        @(negedge clk);
        chk("a_pause_in_end", obs_a(), pk(8'd0, 8'h00, 8'd3, 1'b0, 1'b0, 1'b0));

        // Longer song: pause and resume at address 5.
        for (int i = 0; i < 5; i++) mem_a[i] = 16'h0101;
        mem_a[5] = 16'h5504;
        mem_a[6] = 16'h0000;
        play_a = 1'b1;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            if (ds_a && addr_a == 8'd5) found = 1;
        end
        chk("a_reach_addr5", found, 1);
        chk("a_note5_start", obs_a(), pk(8'd5, 8'h55, 8'd4, 1'b1, 1'b0, 1'b1));
        @(negedge clk);
        chk("a_note5_hold", obs_a(), pk(8'd5, 8'h55, 8'd4, 1'b0, 1'b0, 1'b1));
        play_a = 1'b0;
        @(negedge clk);
        chk("a_pause_silence", obs_a(), pk(8'd5, 8'h00, 8'd4, 1'b0, 1'b0, 1'b0));
        repeat (9) @(negedge clk);
        chk("a_paused_hold", obs_a(), pk(8'd5, 8'h00, 8'd4, 1'b0, 1'b0, 1'b0));
        play_a = 1'b1;
        @(negedge clk);
        chk("a_resume_fetch", obs_a(), pk(8'd5, 8'h00, 8'd4, 1'b0, 1'b0, 1'b1));
        inj_a = 1'b1;
        @(negedge clk);
        inj_a = 1'b0;
        chk("a_fetch_done_ignored", obs_a(), pk(8'd5, 8'h00, 8'd4, 1'b0, 1'b0, 1'b1));
        @(negedge clk);
        chk("a_resume_start", obs_a(), pk(8'd5, 8'h55, 8'd4, 1'b1, 1'b0, 1'b1));
        inj_a = 1'b1;
        @(negedge clk);
        inj_a = 1'b0;
        chk("a_stale_done_ignored", obs_a(), pk(8'd5, 8'h55, 8'd4, 1'b0, 1'b0, 1'b1));
        repeat (3) @(negedge clk);
        play_a = 1'b0;
        @(negedge clk);
        chk("a_pause_beats_done", obs_a(), pk(8'd5, 8'h00, 8'd4, 1'b0, 1'b0, 1'b0));
        inj_a = 1'b1;
        @(negedge clk);
        inj_a = 1'b0;
        chk("a_idle_done_ignored", obs_a(), pk(8'd5, 8'h00, 8'd4, 1'b0, 1'b0, 1'b0));

        // Replay note 5, with a spurious done during its gap.
        play_a = 1'b1;
        repeat (3) @(negedge clk);
        chk("a_replay_start", obs_a(), pk(8'd5, 8'h55, 8'd4, 1'b1, 1'b0, 1'b1));
        repeat (5) @(negedge clk);
        chk("a_gap1", obs_a(), pk(8'd5, 8'h00, 8'd4, 1'b0, 1'b0, 1'b1));
        inj_a = 1'b1;
        @(negedge clk);
        inj_a = 1'b0;
        chk("a_gap2_done_ignored", obs_a(), pk(8'd5, 8'h00, 8'd4, 1'b0, 1'b0, 1'b1));
        @(negedge clk);
        chk("a_fetch_next", obs_a(), pk(8'd6, 8'h00, 8'd4, 1'b0, 1'b0, 1'b1));
        repeat (2) @(negedge clk);
        chk("a_end_marker", obs_a(), pk(8'd0, 8'h00, 8'd4, 1'b0, 1'b1, 1'b1));
        @(negedge clk);
        chk("a_end_to_idle", obs_a(), pk(8'd0, 8'h00, 8'd4, 1'b0, 1'b0, 1'b0));

        // Play on; reset asynchronously in the gap after the note at address 1.
        found = 0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            @(negedge clk);
            if (ds_a && addr_a == 8'd1) found = 1;
        end
        chk("a_reach_addr1", found, 1);
        repeat (2) @(negedge clk);
        chk("a_gap_before_reset", obs_a(), pk(8'd1, 8'h00, 8'd1, 1'b0, 1'b0, 1'b1));
        #2 reset_n = 1'b0;
        #1;
        chk("a_async_reset", obs_a(), 32'd0);
        chk("b_async_reset", obs_b(), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("a_restart_fetch", obs_a(), pk(8'd0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b1));
        repeat (2) @(negedge clk);
        chk("a_restart_note0", obs_a(), pk(8'd0, 8'h01, 8'd1, 1'b1, 1'b0, 1'b1));
        play_a = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, song ROM address width.
REQ-002 Parameter GAP_CYCLES, default 2, silent cycles inserted after each note, range 0..255.
REQ-003 clk  in  1  single system clock; all state changes occur on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 play  in  1  level; 1 = run the song, 0 = pause.
REQ-006 loop  in  1  level; 1 = restart the song at address 0 after the end marker.
REQ-007 rom_addr  out  ADDR_W  song ROM read address.
REQ-008 rom_data  in  16  ROM word: [15:8] pitch code (0 = rest), [7:0] duration (0 = end-of-song marker); valid the cycle after rom_addr is presented.
REQ-009 dur  out  8  duration to the duration timer; held constant from dur_start until the next dur_start.
REQ-010 dur_start  out  1  one-cycle pulse that launches the duration timer.
REQ-011 dur_done  in  1  one-cycle pulse from the duration timer on expiry.
REQ-012 pitch  out  8  pitch code for the tone generator; 0 = silence.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 song_end  out  1  one-cycle pulse when the end marker is decoded.

Function
REQ-015 The block SHALL implement states IDLE, FETCH, LOAD, PLAY, GAP and END.
REQ-016 IDLE: when play=1, go to FETCH; otherwise stay, with pitch=0.
REQ-017 FETCH: rom_addr is stable for one cycle; go to LOAD.
REQ-018 LOAD: if rom_data[7:0]=0, go to END; otherwise register pitch=rom_data[15:8] and dur=rom_data[7:0], assert dur_start for exactly the next cycle, and go to PLAY.
REQ-019 dur_start SHALL be high in the first PLAY cycle, two cycles after the edge on which IDLE sampled play=1.
REQ-020 PLAY: hold pitch and dur; on dur_done=1, go to GAP with pitch=0 from the next cycle.
REQ-021 GAP: count GAP_CYCLES cycles with pitch=0, then increment rom_addr and go to FETCH.
REQ-022 With GAP_CYCLES=0, the increment and the FETCH transition SHALL occur on the dur_done edge, and GAP is skipped.
REQ-023 A pitch code of 0 (rest) SHALL be played as a normal timed note with pitch output 0.
REQ-024 END: pulse song_end for one cycle and set rom_addr=0.
REQ-025 From END, go to FETCH if loop=1 and play=1; otherwise go to IDLE.
REQ-026 rom_addr SHALL wrap from 2^ADDR_W-1 to 0 without an end marker being implied.
REQ-027 play=0 sampled in any non-IDLE state SHALL force IDLE on that edge, set pitch=0 and cancel any pending dur_start.
REQ-028 On pause, rom_addr SHALL be retained; resume replays the current note from its start.
REQ-029 play=0 and dur_done=1 on the same edge: pause wins, and rom_addr is not incremented.
REQ-030 dur_done SHALL be ignored outside PLAY.
REQ-031 dur_done in the same cycle as dur_start SHALL be ignored; it is stale.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 While reset_n=0: state=IDLE, rom_addr=0, dur=0, dur_start=0, pitch=0, busy=0, song_end=0, GAP counter=0.
REQ-034 Reset assertion SHALL take effect immediately, without waiting for clk, including mid-note.
REQ-035 After release, the first transition occurs on the first rising clk edge with reset_n=1.

Verification
REQ-036 ROM {0x4003, 0x0000}, play=1, loop=0, GAP_CYCLES=2, timer model returns dur_done 3 cycles after dur_start -> dur_start at cycle 2 with dur=3 and pitch=0x40; pitch=0 for 2 GAP cycles; song_end pulse; busy=0.
REQ-037 Same ROM with loop=1 -> second dur_start with rom_addr=0; exactly one song_end per pass; no dead cycles beyond FETCH and LOAD.
REQ-038 Drop play to 0 mid-PLAY at rom_addr=5, raise it 10 cycles later -> pitch=0 the next cycle; on resume rom_addr=5 is refetched and dur_start re-pulses with the same dur.
REQ-039 Assert reset_n=0 mid-GAP -> all outputs at reset values with no clk edge; the song restarts from address 0 after release.
REQ-040 ADDR_W=2, ROM {0x1001, 0x0001, 0x2001, 0x3001} with no end marker -> addresses 0,1,2,3,0 are fetched in order, the rest at address 1 gives pitch=0 for its full duration, and song_end never pulses.
REQ-041 dur_done injected in IDLE, FETCH and GAP, and dur_done coincident with play falling -> no state advance and no address increment.
